i2c_bus_arbiter: RTL and testbench
==================================

Name: i2c_bus_arbiter

Overview:
- Shares the single byte-level I2C master between two register-write requesters: requester 0 is the camera ROM config sequencer, requester 1 is the runtime register writer (exposure/gain tweaks).
- Performs round-robin arbitration and sequences one 2-byte write (register address, then register data) per grant.
- Drives the master's transmit/data/slave-address inputs and returns a one-cycle done or error pulse to the granted requester.
- Adds an activity timeout so a hung master or slave cannot lock the bus.

Parameters:
- TIMEOUT, 16'd50000: I2C_Clock cycles allowed in any single active state before abort.
- MAX_RETRY, 2: NACK retries per transaction; used only with I2C_RETRY_EN.

Ports:
- I2C_Clock  in  1  clock.
- iReset  in  1  reset, asynchronous, active-low.
- iReq0  in  1  requester 0 transaction request; held until oDone0/oErr0.
- iSlv_Addr0  in  7  requester 0 7-bit slave address.
- iReg_Addr0  in  8  requester 0 register address.
- iReg_Data0  in  8  requester 0 register data.
- oGrant0  out  1  high while requester 0 owns the bus.
- oDone0  out  1  one-cycle pulse: write completed and acked.
- oErr0  out  1  one-cycle pulse: NACK or timeout.
- iReq1, iSlv_Addr1, iReg_Addr1, iReg_Data1, oGrant1, oDone1, oErr1: same as above for requester 1.
- iI2C_Ready  in  1  master idle and able to start.
- iAck  in  1  high: master latched the current byte and wants the next; returns low: slave acked.
- iNack  in  1  slave NACK or transfer failure.
- oTransmit  out  1  transfer request to the master.
- oSlv_Addr  out  7  slave address to the master.
- oI2C_Data  out  8  byte to the master.
- oBusy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any state, including mid-transfer): state=IDLE; oTransmit=0; oSlv_Addr=0; oI2C_Data=0; all grants, done and error outputs 0; oBusy=0; last_grant=1, so requester 0 wins the first tie; timeout counter=0; retry count=0.
- IDLE → ARB when iReq0 or iReq1 is high.
- ARB, 1 cycle:
  - Picks the requester that is not last_grant if both request; otherwise the sole requester.
  - Latches its slave address, register address and data into internal registers.
  - Sets oGrantN and updates last_grant.
  - Goes to START.
- START: when iI2C_Ready=1, drive oTransmit=1, oSlv_Addr=latched slave address, oI2C_Data=register address; go to ADDR.
- ADDR: on iAck=1, drive oI2C_Data=register data, keep oTransmit=1; go to ACK1.
- ACK1:
  - iNack=1 → FAIL.
  - Otherwise iAck=0 → DATA.
- DATA: on iAck=1, drive oTransmit=0; go to ACK2.
- ACK2:
  - iNack=1 → FAIL.
  - Otherwise iAck=0 → DONE.
- DONE, 1 cycle: oDoneN=1, oGrantN=0, oTransmit=0; go to IDLE.
- FAIL, 1 cycle: oTransmit=0, oErrN=1, oGrantN=0; go to IDLE.
- iNack takes priority over iAck in the same cycle.
- Response pulses occur exactly one cycle after the terminating event.
- The requester drops iReq the cycle after its pulse. IDLE always lasts at least 1 cycle after DONE/FAIL, so a requester still high is not double-granted; the other requester wins the next ARB if it is pending.
- Timeout:
  - The 16-bit counter clears on every state change and increments while the state is START, ADDR, ACK1, DATA or ACK2.
  - counter==TIMEOUT-1 → FAIL (oErrN pulse), oTransmit=0.
  - The counter saturates and does not wrap.
- Requester inputs are sampled only in ARB; changes during a transaction are ignored.
- oGrant0 and oGrant1 are never high together.
- Latency from request to first oTransmit, with iI2C_Ready already 1: 3 cycles (IDLE→ARB→START→transmit).

Optional Feature:
- Macro: I2C_RETRY_EN.
- When defined:
  - A NACK in ACK1/ACK2 with retry count < MAX_RETRY goes to state RETRY instead of FAIL.
  - RETRY: oTransmit=0, increments the retry count, keeps the grant and latched data, and returns to START.
  - A NACK with retry count == MAX_RETRY goes to FAIL.
  - A timeout always goes straight to FAIL (no retry).
  - The retry count clears in ARB.
- When undefined: the first NACK goes to FAIL; no RETRY state or retry counter exists.

Test Plan:
- Single request: iReq0=1, slave 7'h21, reg 8'h12, data 8'h80; master model acks both bytes → oTransmit bytes 12 then 80 on oI2C_Data, oSlv_Addr=21, oDone0 one-cycle pulse, oErr0=0, oGrant1 stays 0.
- Simultaneous iReq0 and iReq1 out of reset → requester 0 is served first and oDone0 pulses; requester 1 is then granted after ≥1 IDLE cycle. Repeat with both held → grants alternate 1,0,1.
- NACK on the data byte, I2C_RETRY_EN undefined → oErr0 pulse the cycle after iNack, oTransmit=0, state IDLE; no second attempt.
- NACK on every attempt, I2C_RETRY_EN defined, MAX_RETRY=2 → exactly 3 register-address bytes are transmitted, then one oErr1 pulse. NACK only on the first attempt → oDone1 after 2 attempts.
- iI2C_Ready held 0 with TIMEOUT=16'd20 → oErr0 pulses 20 cycles after entering START; oTransmit never asserts.
- iReset low in the ACK1 state → oTransmit, grants and oBusy are 0 immediately. After release, a pending iReq0 is granted before iReq1 and the transaction restarts from the register-address byte.

Source files
------------

// File: rtl/i2c_bus_arbiter.sv
// rtl/i2c_bus_arbiter.sv - round-robin arbiter sequencing 2-byte I2C register writes for two requesters
// Optional NACK retry is compiled in when I2C_RETRY_EN is defined.
module i2c_bus_arbiter #(
  parameter logic [15:0] TIMEOUT   = 16'd50000,
  parameter int          MAX_RETRY = 2
) (
  input  logic       I2C_Clock,
  input  logic       iReset,
  input  logic       iReq0,
  input  logic [6:0] iSlv_Addr0,
  input  logic [7:0] iReg_Addr0,
  input  logic [7:0] iReg_Data0,
  output logic       oGrant0,
  output logic       oDone0,
  output logic       oErr0,
  input  logic       iReq1,
  input  logic [6:0] iSlv_Addr1,
  input  logic [7:0] iReg_Addr1,
  input  logic [7:0] iReg_Data1,
  output logic       oGrant1,
  output logic       oDone1,
  output logic       oErr1,
  input  logic       iI2C_Ready,
  input  logic       iAck,
  input  logic       iNack,
  output logic       oTransmit,
  output logic [6:0] oSlv_Addr,
  output logic [7:0] oI2C_Data,
  output logic       oBusy
);

  typedef enum logic [3:0] {
    IDLE, ARB, START, ADDR, ACK1, DATA, ACK2, DONE, FAIL
`ifdef I2C_RETRY_EN
    , RETRY
`endif
  } state_t;

  state_t      state, state_d, nack_target;
  logic        transmit_d;
  logic [6:0]  slv_d;
  logic [7:0]  data_d;
  logic [1:0]  grant_d;
  logic        pick, owner, last_grant;
  logic [6:0]  lat_slv;
  logic [7:0]  lat_reg, lat_dat;
  logic [15:0] tmo_cnt;
  logic        active, timed_out;

  // On a tie the requester that did not win last time is served.
  assign pick      = (iReq0 && iReq1) ? ~last_grant : iReq1;
  assign active    = (state == START) || (state == ADDR) || (state == ACK1) ||
                     (state == DATA)  || (state == ACK2);
  assign timed_out = active && (tmo_cnt == TIMEOUT - 16'd1);

  assign oBusy  = (state != IDLE);
  assign oDone0 = (state == DONE) && !owner;
  assign oDone1 = (state == DONE) &&  owner;
  assign oErr0  = (state == FAIL) && !owner;
  assign oErr1  = (state == FAIL) &&  owner;

`ifdef I2C_RETRY_EN
  logic [3:0] retry_cnt;
  assign nack_target = (retry_cnt < 4'(MAX_RETRY)) ? RETRY : FAIL;

  always_ff @(posedge I2C_Clock or negedge iReset) begin
    if (!iReset)             retry_cnt <= 4'd0;
    else if (state == ARB)   retry_cnt <= 4'd0;
    else if (state == RETRY) retry_cnt <= retry_cnt + 4'd1;
  end
`else
  localparam int unused_max_retry = MAX_RETRY;
  assign nack_target = FAIL;
`endif

  always_comb begin
    state_d    = state;
    transmit_d = oTransmit;
    slv_d      = oSlv_Addr;
    data_d     = oI2C_Data;
    grant_d    = {oGrant1, oGrant0};
    case (state)
      IDLE:  if (iReq0 || iReq1) state_d = ARB;
      ARB: begin
        grant_d = pick ? 2'b10 : 2'b01;
        state_d = START;
      end
      START: if (iI2C_Ready) begin
        transmit_d = 1'b1;
        slv_d      = lat_slv;
        data_d     = lat_reg;
        state_d    = ADDR;
      end
      ADDR:  if (iAck) begin
        data_d  = lat_dat;
        state_d = ACK1;
      end
      ACK1:  if (iNack) state_d = nack_target;
             else if (!iAck) state_d = DATA;
      DATA:  if (iAck) begin
        transmit_d = 1'b0;
        state_d    = ACK2;
      end
      ACK2:  if (iNack) state_d = nack_target;
             else if (!iAck) state_d = DONE;
`ifdef I2C_RETRY_EN
      RETRY: state_d = START;
`endif
      default: state_d = IDLE;
    endcase
    // Timeout overrides any other move and never retries.
    if (timed_out) state_d = FAIL;
    if (state_d == DONE || state_d == FAIL) begin
      transmit_d = 1'b0;
      grant_d    = 2'b00;
    end
`ifdef I2C_RETRY_EN
    if (state_d == RETRY) transmit_d = 1'b0;
`endif
  end

  always_ff @(posedge I2C_Clock or negedge iReset) begin
    if (!iReset) begin
      state      <= IDLE;
      oTransmit  <= 1'b0;
      oSlv_Addr  <= 7'd0;
      oI2C_Data  <= 8'd0;
      oGrant0    <= 1'b0;
      oGrant1    <= 1'b0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      lat_slv    <= 7'd0;
      lat_reg    <= 8'd0;
      lat_dat    <= 8'd0;
      tmo_cnt    <= 16'd0;
    end else begin
      state     <= state_d;
      oTransmit <= transmit_d;
      oSlv_Addr <= slv_d;
      oI2C_Data <= data_d;
      oGrant0   <= grant_d[0];
      oGrant1   <= grant_d[1];
      if (state == ARB) begin
        owner      <= pick;
        last_grant <= pick;
        lat_slv    <= pick ? iSlv_Addr1 : iSlv_Addr0;
        lat_reg    <= pick ? iReg_Addr1 : iReg_Addr0;
        lat_dat    <= pick ? iReg_Data1 : iReg_Data0;
      end
      if (state_d != state)                   tmo_cnt <= 16'd0;
      else if (active && tmo_cnt != 16'hFFFF) tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb/tb_i2c_bus_arbiter.sv - directed-vector bench for i2c_bus_arbiter with a scripted byte-level master
// Retry scenarios are exercised when I2C_RETRY_EN is defined.
module tb_i2c_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, grant0, grant1, done0, done1, err0, err1;
  logic [6:0] slv0, slv1, tx_slv;
  logic [7:0] ra0, ra1, rd0, rd1, tx_data;
  logic       ready, ack, nack, transmit, busy;
  int         n_vec = 0;
  int         n_bad = 0;
  logic       mon_en = 1'b0;

  always #5 clk = ~clk;

  i2c_bus_arbiter #(.TIMEOUT(16'd20), .MAX_RETRY(2)) dut (
    .I2C_Clock(clk), .iReset(rst_n),
    .iReq0(req0), .iSlv_Addr0(slv0), .iReg_Addr0(ra0), .iReg_Data0(rd0),
    .oGrant0(grant0), .oDone0(done0), .oErr0(err0),
    .iReq1(req1), .iSlv_Addr1(slv1), .iReg_Addr1(ra1), .iReg_Data1(rd1),
    .oGrant1(grant1), .oDone1(done1), .oErr1(err1),
    .iI2C_Ready(ready), .iAck(ack), .iNack(nack),
    .oTransmit(transmit), .oSlv_Addr(tx_slv), .oI2C_Data(tx_data), .oBusy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (mon_en) check("grant_mutex", grant0 & grant1, 0);

  task automatic wait_tx(input int exp_lat);
    int lat;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (transmit) begin lat = i; break; end
    end
    check("latency", lat, exp_lat);
  endtask

  // Full 2-byte write; nack_data NACKs the data byte.
  task automatic xact(input logic who, input logic [6:0] slv, input logic [7:0] ra,
                      input logic [7:0] rd, input logic nack_data, input int exp_lat);
    wait_tx(exp_lat);
    check("slv_addr", tx_slv, slv);
    check("reg_addr_byte", tx_data, ra);
    check("grant_own", who ? grant1 : grant0, 1);
    check("grant_other", who ? grant0 : grant1, 0);
    ack = 1; @(negedge clk);
    check("reg_data_byte", tx_data, rd);
    check("tx_held", transmit, 1);
    ack = 0; @(negedge clk);
    ack = 1; @(negedge clk);
    check("tx_dropped", transmit, 0);
    ack = 0; nack = nack_data; @(negedge clk);
    nack = 0;
    check("done_pulse", who ? done1 : done0, !nack_data);
    check("err_pulse", who ? err1 : err0, nack_data);
    check("grant_released", who ? grant1 : grant0, 0);
    @(negedge clk);
    check("idle_gap", busy, 0);
    check("pulse_one_cycle", who ? (done1 | err1) : (done0 | err0), 0);
  endtask

  task automatic do_reset();
    rst_n = 0; @(negedge clk); @(negedge clk); rst_n = 1;
  endtask

`ifdef I2C_RETRY_EN
  task automatic nack_attempt(input logic [7:0] ra, input int exp_lat, input logic exp_err);
    wait_tx(exp_lat);
    check("retry_reg_addr", tx_data, ra);
    ack = 1; @(negedge clk);
    ack = 0; nack = 1; @(negedge clk);
    nack = 0;
    check("retry_tx_off", transmit, 0);
    check("retry_err", err1, exp_err);
    check("retry_grant", grant1, !exp_err);
  endtask
`endif

  initial begin
    int tx_seen;
    rst_n = 0; req0 = 0; req1 = 0; ready = 1; ack = 0; nack = 0;
    slv0 = 7'h21; ra0 = 8'h12; rd0 = 8'h80;
    slv1 = 7'h35; ra1 = 8'h4A; rd1 = 8'hC3;
    @(negedge clk); @(negedge clk);
    check("rst_transmit", transmit, 0);
    check("rst_grants", {grant1, grant0}, 0);
    check("rst_pulses", {done1, done0, err1, err0}, 0);
    check("rst_busy", busy, 0);
    check("rst_slv", tx_slv, 0);
    check("rst_data", tx_data, 0);
    rst_n = 1; mon_en = 1;
    @(negedge clk);

    // Single request from requester 0.
    req0 = 1;
    xact(0, 7'h21, 8'h12, 8'h80, 0, 3);
    req0 = 0;

    // Ties out of reset: 0 first, then alternation while both stay requesting.
    do_reset();
    req0 = 1; req1 = 1;
    xact(0, 7'h21, 8'h12, 8'h80, 0, 3);
    xact(1, 7'h35, 8'h4A, 8'hC3, 0, 3);
    xact(0, 7'h21, 8'h12, 8'h80, 0, 3);
    xact(1, 7'h35, 8'h4A, 8'hC3, 0, 3);
    req0 = 0; req1 = 0;

`ifdef I2C_RETRY_EN
    req1 = 1;
    nack_attempt(8'h4A, 3, 0);
    nack_attempt(8'h4A, 2, 0);
    nack_attempt(8'h4A, 2, 1);
    req1 = 0;
    tx_seen = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (transmit) tx_seen++; end
    check("no_fourth_attempt", tx_seen, 0);
    req1 = 1;
    nack_attempt(8'h4A, 3, 0);
    xact(1, 7'h35, 8'h4A, 8'hC3, 0, 2);
    req1 = 0;
`else
    req0 = 1;
    xact(0, 7'h21, 8'h12, 8'h80, 1, 3);
    req0 = 0;
    tx_seen = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (transmit || busy) tx_seen++; end
    check("no_second_attempt", tx_seen, 0);
`endif

    // Master never ready: abort TIMEOUT cycles after entering START.
    ready = 0; req0 = 1; tx_seen = 0;
    begin
      int hit;
      hit = 0;
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk);
        if (transmit) tx_seen++;
        if (err0) begin hit = i; break; end
      end
      check("timeout_cycles", hit, 22);
    end
    check("timeout_no_tx", tx_seen, 0);
    check("timeout_grant", grant0, 0);
    req0 = 0; ready = 1;
    @(negedge clk); @(negedge clk);

    // Reset in ACK1 with both requesters pending.
    req0 = 1;
    wait_tx(3);
    ack = 1; @(negedge clk);
    req1 = 1; ack = 0;
    rst_n = 0; #1;
    check("arst_transmit", transmit, 0);
    check("arst_grants", {grant1, grant0}, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1;
    xact(0, 7'h21, 8'h12, 8'h80, 0, 3);
    req0 = 0;
    xact(1, 7'h35, 8'h4A, 8'hC3, 0, 3);
    req1 = 0;
    @(negedge clk);

    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
